// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider, one quotient bit per clock.
// Result packed as {remainder, quotient} (HI:LO) with busy/done handshake.
module seq_divider #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   dividend,
   input  logic [WIDTH-1:0]   divisor,
   output logic               busy,
   output logic               done,
   output logic               div_zero,
   output logic [2*WIDTH-1:0] out
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
   state_e             state_q, state_d;
   logic [WIDTH:0]     rem_q, rem_d, shifted, diff;
   logic [WIDTH-1:0]   quot_q, quot_d, dvs_q, dvs_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] out_q, out_d;
   logic               dz_q, dz_d;
   assign shifted  = {rem_q[WIDTH-1:0], quot_q[WIDTH-1]};
   assign diff     = shifted - {1'b0, dvs_q};
   assign busy     = state_q != IDLE;
   assign done     = state_q == DONE;
   assign div_zero = dz_q;
   assign out      = out_q;
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      quot_d  = quot_q;
      dvs_d   = dvs_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      dz_d    = dz_q;
      case (state_q)
         IDLE: if (start) begin
            rem_d   = '0;
            quot_d  = dividend;
            dvs_d   = divisor;
            cnt_d   = '0;
            state_d = (divisor == '0) ? DONE : RUN;
            if (divisor == '0) begin
               out_d = {dividend, {WIDTH{1'b1}}};
               dz_d  = 1'b1;
            end
         end
         RUN: begin
            // a borrow out of the WIDTH+1-bit subtraction means the divisor did not fit
            rem_d  = diff[WIDTH] ? shifted : diff;
            quot_d = {quot_q[WIDTH-2:0], ~diff[WIDTH]};
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH-1)) begin
               state_d = DONE;
               out_d   = {rem_d[WIDTH-1:0], quot_d};
               dz_d    = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         rem_q   <= '0;
         quot_q  <= '0;
         dvs_q   <= '0;
         cnt_q   <= '0;
         out_q   <= '0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         quot_q  <= quot_d;
         dvs_q   <= dvs_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         dz_q    <= dz_d;
      end
   end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and random vectors against seq_divider with bench-computed results.
module tb_seq_divider;
   logic        clk = 1'b0;
   logic        rst, start, busy, done, div_zero;
   logic [31:0] dividend, divisor;
   logic [63:0] out;
   int          nvec = 0, nmis = 0;

   seq_divider #(.WIDTH(32), .CNT_W(6)) dut (
      .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
      .busy(busy), .done(done), .div_zero(div_zero), .out(out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // drives one operation from start to return-to-IDLE; n counts edges from the accepting edge
   task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input bit poke);
      int          n, nb;
      logic [31:0] eq, er;
      bit          dz;
      dz = (b == 0);
      if (dz) begin eq = '1; er = a; end
      else    begin eq = a / b; er = a % b; end
      @(negedge clk);
      start = 1'b1; dividend = a; divisor = b;
      @(negedge clk);
      start = 1'b0; dividend = $urandom; divisor = $urandom;
      n = 1; nb = int'(busy);
      while (!done && n < 60) begin
         if (poke && n == 10) begin start = 1'b1; dividend = 50; divisor = 5; end
         @(negedge clk);
         start = 1'b0; n++; nb += int'(busy);
      end
      check({tag, ".lat"},  64'(n),  dz ? 64'd1 : 64'd33);
      check({tag, ".busy"}, 64'(nb), dz ? 64'd1 : 64'd33);
      check({tag, ".out"},  out, {er, eq});
      check({tag, ".dz"},   64'(div_zero), 64'(dz));
      if (poke) begin start = 1'b1; dividend = 50; divisor = 5; end
      @(negedge clk);
      start = 1'b0;
      check({tag, ".idle"}, {62'd0, busy, done}, 64'd0);
      check({tag, ".hold"}, out, {er, eq});
   endtask

   initial begin
      int nd;
      logic [31:0] a, b;
      rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst.busy", 64'(busy), 64'd0);
      check("rst.done", 64'(done), 64'd0);
      check("rst.dz",   64'(div_zero), 64'd0);
      check("rst.out",  out, 64'd0);

      do_op("d100_7", 32'd100, 32'd7, 1'b0);
      check("d100_7.val", out, {32'd2, 32'd14});
      do_op("dmax_1", 32'hFFFF_FFFF, 32'd1, 1'b0);
      check("dmax_1.val", out, {32'd0, 32'hFFFF_FFFF});
      do_op("d5_max", 32'd5, 32'hFFFF_FFFF, 1'b0);
      check("d5_max.val", out, {32'd5, 32'd0});
      do_op("dzero", 32'h1234_5678, 32'd0, 1'b0);
      check("dzero.val", out, {32'h1234_5678, 32'hFFFF_FFFF});
      check("dzero.flag", 64'(div_zero), 64'd1);
      do_op("d9_3", 32'd9, 32'd3, 1'b0);
      check("d9_3.val", out, {32'd0, 32'd3});
      check("d9_3.flag", 64'(div_zero), 64'd0);
      do_op("poke", 32'd100, 32'd7, 1'b1);
      check("poke.val", out, {32'd2, 32'd14});

      // reset together with start: the request must not be taken
      @(negedge clk);
      rst = 1'b1; start = 1'b1; dividend = 32'd10; divisor = 32'd2;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      check("rststart.busy", 64'(busy), 64'd0);

      // abort mid-run
      @(negedge clk);
      start = 1'b1; dividend = 32'd1000; divisor = 32'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      check("abort.busy_pre", 64'(busy), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort.busy", 64'(busy), 64'd0);
      check("abort.done", 64'(done), 64'd0);
      check("abort.out",  out, 64'd0);
      nd = 0;
      repeat (40) begin @(negedge clk); nd += int'(done); end
      check("abort.nodone", 64'(nd), 64'd0);
      do_op("fresh", 32'd1000, 32'd3, 1'b0);
      check("fresh.val", out, {32'd1, 32'd333});

      for (int i = 0; i < 1000; i++) begin
         a = $urandom;
         b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 255)) : $urandom;
         if (b == 0) b = 1;
         do_op("rand", a, b, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule
